sequential_divider: RTL and testbench
=====================================

# sequential_divider

Multi-cycle signed integer divider, the inverse-operation companion to the sequential multiplier in the MiniProject2 datapath. It accepts an N-bit two's-complement dividend and divisor on a start pulse and runs one restoring-division step per clock. It returns an N-bit quotient and an N-bit remainder with a done pulse. Results round toward zero, and the remainder takes the sign of the dividend.

## Interface
- `N`, default 32: operand and result width in bits; must be at least 2.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a division; sampled only while idle.
- `in1` input N: dividend, two's complement; captured on the accepting edge.
- `in2` input N: divisor, two's complement; captured on the accepting edge.
- `busy` output 1: high from the accepting edge until `done` deasserts.
- `done` output 1: one-cycle pulse; results are valid from this cycle on.
- `quotient` output N: signed quotient; held until the next accepted start.
- `remainder` output N: signed remainder; held until the next accepted start.
- `dzflag` output 1: the divisor was zero; held with the results.
- `ovflag` output 1: the operation was the most-negative value divided by -1; held with the results.

## Operation
- Reset (asynchronous assert, synchronous release): the state goes to IDLE and `busy`, `done`, `quotient`, `remainder`, `dzflag` and `ovflag` all go to 0.
- States:
  - IDLE → CALC on `start`=1.
  - CALC stays in CALC while the step counter is nonzero; CALC → FIX when the counter reaches 0.
  - FIX → DONE.
  - DONE → IDLE unconditionally.
- Accept (in IDLE with `start`=1):
  - Latch `|in1|` and `|in2|` as N-bit unsigned magnitudes; the most-negative value maps to 2^(N-1).
  - Latch the sign of `in1` and the XOR of the operand signs.
  - Latch `in2`==0 and the overflow condition (`in1`=100…0 and `in2`=all ones).
  - Clear the N+1-bit partial remainder and load the counter with N.
- Each CALC cycle performs one restoring step:
  - Shift the partial remainder left, bringing in the dividend MSB.
  - Trial-subtract the divisor.
  - If the trial result is non-negative, keep it and shift 1 into the quotient; otherwise restore and shift 0.
  - Decrement the counter.
- FIX cycle:
  - Negate the quotient if the latched sign XOR is 1.
  - Negate the remainder if the dividend was negative.
  - Register the results and flags.
- Divide by zero: the iteration still runs its full length, so latency stays deterministic. Results are forced to `quotient` = all ones, `remainder` = `in1`, and `dzflag`=1.
- Overflow: results are forced to `quotient` = 100…0, `remainder` = 0, and `ovflag`=1.
- Width rules: the partial remainder is N+1 bits and all internal arithmetic is unsigned magnitude. Sign correction happens only in FIX.
- `start` while `busy`=1 is ignored; it is neither queued nor allowed to corrupt the operation in flight.
- `start` held high through DONE is accepted on the first IDLE cycle.
- Reset asserted mid-operation aborts immediately to the reset state; no `done` is produced.

## Timing
- Call the accepting edge E0. CALC occupies edges E1..EN, FIX happens on EN+1, and `done`=1 in the cycle after EN+1.
- Start-to-done latency is N+2 cycles: 34 cycles for N=32.
- `busy` rises after E0 and falls together with `done`.
- Back-to-back throughput is one result every N+3 cycles. The earliest next accept is the edge ending the IDLE cycle after DONE.
- Outputs are registered with no combinational path from inputs to outputs. The results change only on the FIX edge.

## Structure
- Package `div_pkg` holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - the default width constant `DIV_N`=32;
  - a function returning the two's-complement magnitude of an N-bit value.
- Sub-module `div_step`: a combinational single restoring step. It takes partial remainder, divisor and incoming bit, and returns the next partial remainder and the quotient bit. It is instantiated once and reused every CALC cycle.
- The top level holds the FSM, the counter, the operand registers and the sign-fix logic.

## Test plan
- 100 / 7 → `quotient`=14, `remainder`=2, both flags 0; `done` exactly 34 cycles after the accepting edge.
- -100 / 7 → `quotient`=0xFFFFFFF2 (-14), `remainder`=0xFFFFFFFE (-2). Then 100 / -7 → `quotient`=-14, `remainder`=2.
- 0x80000000 / 0xFFFFFFFF → `quotient`=0x80000000, `remainder`=0, `ovflag`=1. Then 0x80000000 / 2 → `quotient`=0xC0000000, `remainder`=0.
- 5 / 0 → `quotient`=0xFFFFFFFF, `remainder`=5, `dzflag`=1; latency still 34 cycles.
- Pulse `start` with 9 / 3 while busy on a run of 50 / 4 → the 9 / 3 request is ignored. Result is `quotient`=12, `remainder`=2; a following clean start of 9 / 3 returns 3 / 0.
- Assert `rst_n`=0 at cycle 10 of a running division → all outputs 0 immediately, no `done` pulse. After release, 1 / 1 returns `quotient`=1, `remainder`=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   - div_state_e : FSM state encoding (IDLE, CALC, FIX, DONE)
//   - DIV_N       : default operand/result width
//   - MAG_W       : widest operand the magnitude helper supports
//   - magnitude() : two's-complement magnitude of a sign-extended value
package div_pkg;

    localparam int DIV_N = 32;
    localparam int MAG_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Callers sign-extend an N-bit operand to MAG_W bits and truncate the
    // result back to N bits. The most-negative N-bit value then maps to
    // 2^(N-1), which still fits in N unsigned bits.
    function automatic logic [MAG_W-1:0] magnitude(input logic [MAG_W-1:0] v);
        logic [MAG_W-1:0] m;
        if (v[MAG_W-1]) begin
            m = ~v + 64'd1;
        end else begin
            m = v;
        end
        return m;
    endfunction

endpackage

// File: rtl/sequential_divider_if.sv
// Handshake and data bundle of the sequential divider.
//   master : drives start/in1/in2, observes busy/done/results/flags
//   slave  : the divider side
interface sequential_divider_if
    import div_pkg::*;
#(
    parameter int N = DIV_N
) ();

    logic         start;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         dzflag;
    logic         ovflag;

    modport master (
        output start, in1, in2,
        input  busy, done, quotient, remainder, dzflag, ovflag
    );

    modport slave (
        input  start, in1, in2,
        output busy, done, quotient, remainder, dzflag, ovflag
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
//   prem     : current N+1-bit partial remainder
//   dsr      : N-bit divisor magnitude
//   din      : dividend bit shifted in this step
//   prem_nxt : next partial remainder
//   qbit     : quotient bit produced by this step
module div_step #(
    parameter int N = 32
) (
    input  logic [N:0]   prem,
    input  logic [N-1:0] dsr,
    input  logic         din,
    output logic [N:0]   prem_nxt,
    output logic         qbit
);

    logic [N+1:0] shifted_s;
    logic [N+1:0] trial_s;

    // Shift, trial-subtract, keep or restore. One extra bit makes the
    // trial result's MSB a reliable sign bit.
    always_comb begin
        shifted_s = {prem, din};
        trial_s   = shifted_s - {2'b00, dsr};
        if (trial_s[N+1]) begin
            qbit     = 1'b0;
            prem_nxt = shifted_s[N:0];
        end else begin
            qbit     = 1'b1;
            prem_nxt = trial_s[N:0];
        end
    end

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle signed divider: one restoring step per clock, quotient rounds
// toward zero, remainder takes the dividend's sign.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : start/in1/in2 in; busy/done/quotient/remainder/dzflag/ovflag out
// Latency from the accepting edge to the done cycle is N+2 cycles.
module sequential_divider
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sequential_divider_if.slave  bus
);

    localparam int           CW       = $clog2(N + 1);
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
    localparam logic [N-1:0] ZERO_N   = {N{1'b0}};

    div_state_e    state_r;
    div_state_e    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [N-1:0]  dvd_r;        // dividend magnitude, becomes the quotient
    logic [N-1:0]  dsr_r;
    logic [N-1:0]  in1_r;
    logic [N:0]    prem_r;
    logic          sign_q_r;
    logic          sign_dvd_r;
    logic          dz_r;
    logic          ov_r;

    logic          busy_r;
    logic          done_r;
    logic [N-1:0]  quot_r;
    logic [N-1:0]  rem_r;
    logic          dzflag_r;
    logic          ovflag_r;

    logic          accept_s;
    logic [N-1:0]  mag1_s;
    logic [N-1:0]  mag2_s;
    logic [N:0]    prem_nxt_s;
    logic          qbit_s;
    logic [N-1:0]  quot_fix_s;
    logic [N-1:0]  rem_fix_s;

    assign accept_s = (state_r == IDLE) && bus.start;
    assign mag1_s   = N'(magnitude(MAG_W'($signed(bus.in1))));
    assign mag2_s   = N'(magnitude(MAG_W'($signed(bus.in2))));

    div_step #(.N(N)) u_step (
        .prem     (prem_r),
        .dsr      (dsr_r),
        .din      (dvd_r[N-1]),
        .prem_nxt (prem_nxt_s),
        .qbit     (qbit_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; CALC leaves on the edge that takes the counter to 0.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CW'(1)) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIX:     state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sign correction and special-case overrides applied on the FIX edge.
    always_comb begin
        quot_fix_s = dvd_r;
        rem_fix_s  = N'(prem_r);
        if (dz_r) begin
            quot_fix_s = ALL_ONES;
            rem_fix_s  = in1_r;
        end else if (ov_r) begin
            quot_fix_s = MOST_NEG;
            rem_fix_s  = ZERO_N;
        end else begin
            if (sign_q_r) begin
                quot_fix_s = ZERO_N - dvd_r;
            end else begin
                quot_fix_s = dvd_r;
            end
            if (sign_dvd_r) begin
                rem_fix_s = ZERO_N - N'(prem_r);
            end else begin
                rem_fix_s = N'(prem_r);
            end
        end
    end

    // Operand capture, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {CW{1'b0}};
            dvd_r      <= ZERO_N;
            dsr_r      <= ZERO_N;
            in1_r      <= ZERO_N;
            prem_r     <= {(N+1){1'b0}};
            sign_q_r   <= 1'b0;
            sign_dvd_r <= 1'b0;
            dz_r       <= 1'b0;
            ov_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            quot_r     <= ZERO_N;
            rem_r      <= ZERO_N;
            dzflag_r   <= 1'b0;
            ovflag_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        dvd_r      <= mag1_s;
                        dsr_r      <= mag2_s;
                        in1_r      <= bus.in1;
                        prem_r     <= {(N+1){1'b0}};
                        cnt_r      <= CW'(N);
                        sign_q_r   <= bus.in1[N-1] ^ bus.in2[N-1];
                        sign_dvd_r <= bus.in1[N-1];
                        dz_r       <= (bus.in2 == ZERO_N);
                        ov_r       <= (bus.in1 == MOST_NEG) && (bus.in2 == ALL_ONES);
                        busy_r     <= 1'b1;
                    end
                end
                CALC: begin
                    prem_r <= prem_nxt_s;
                    dvd_r  <= {dvd_r[N-2:0], qbit_s};
                    cnt_r  <= cnt_r - CW'(1);
                end
                FIX: begin
                    quot_r   <= quot_fix_s;
                    rem_r    <= rem_fix_s;
                    dzflag_r <= dz_r;
                    ovflag_r <= ov_r;
                    done_r   <= 1'b1;
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quot_r;
    assign bus.remainder = rem_r;
    assign bus.dzflag    = dzflag_r;
    assign bus.ovflag    = ovflag_r;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider (N=32): directed cases,
// start-while-busy, mid-operation reset, held start, random operands.
module tb_sequential_divider;

    localparam int N   = 32;
    localparam int LAT = N + 2;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    sequential_divider_if #(.N(N)) dif ();

    sequential_divider #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed arithmetic (truncating division).
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz, output logic ov);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        dz = (b == 32'd0);
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (dz) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (ov) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = $urandom_range(0, 40);
            4:       v = 32'd0 - 32'($urandom_range(1, 40));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one division; optionally pulse start with other operands on
    // cycle 'poke'. lat = cycle index (1 = first cycle after accept) of done.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input int poke, input logic [31:0] pa, input logic [31:0] pb,
                           output logic [31:0] q, output logic [31:0] r,
                           output logic dz, output logic ov, output int lat);
        @(negedge clk);
        dif.start = 1'b1;
        dif.in1   = a;
        dif.in2   = b;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dif.in1   = $urandom;
        dif.in2   = $urandom;
        lat = 999;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == poke) begin
                dif.start = 1'b1;
                dif.in1   = pa;
                dif.in2   = pb;
            end else begin
                dif.start = 1'b0;
            end
            if (dif.done) begin
                lat = c;
                break;
            end
        end
        dif.start = 1'b0;
        q  = dif.quotient;
        r  = dif.remainder;
        dz = dif.dzflag;
        ov = dif.ovflag;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (dif.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", dif.busy); end
        checks++; if (dif.done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b want 0", dif.done); end
        checks++; if (dif.quotient !== 32'd0)  begin errors++; $display("FAIL reset_quotient: got %h want 0", dif.quotient); end
        checks++; if (dif.remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder: got %h want 0", dif.remainder); end
        checks++; if (dif.dzflag !== 1'b0)     begin errors++; $display("FAIL reset_dzflag: got %b want 0", dif.dzflag); end
        checks++; if (dif.ovflag !== 1'b0)     begin errors++; $display("FAIL reset_ovflag: got %b want 0", dif.ovflag); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'd5};
        logic [31:0] tb [6] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd2, 32'd0};
        logic [31:0] eq [6] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'h8000_0000, 32'hC000_0000, 32'hFFFF_FFFF};
        logic [31:0] er [6] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'd0, 32'd0, 32'd5};
        logic        ed [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        eo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] q, r;
        logic        dz, ov;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_div(ta[i], tb[i], 0, 32'd0, 32'd0, q, r, dz, ov, lat);
            checks++; if (q !== eq[i])  begin errors++; $display("FAIL dir%0d_quotient: got %h want %h", i, q, eq[i]); end
            checks++; if (r !== er[i])  begin errors++; $display("FAIL dir%0d_remainder: got %h want %h", i, r, er[i]); end
            checks++; if (dz !== ed[i]) begin errors++; $display("FAIL dir%0d_dzflag: got %b want %b", i, dz, ed[i]); end
            checks++; if (ov !== eo[i]) begin errors++; $display("FAIL dir%0d_ovflag: got %b want %b", i, ov, eo[i]); end
            checks++; if (lat != LAT)   begin errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT); end
            if (i == 0) begin
                // done must be a single pulse; busy falls with it; results hold
                @(negedge clk);
                checks++; if (dif.done !== 1'b0)      begin errors++; $display("FAIL done_pulse: got %b want 0", dif.done); end
                checks++; if (dif.busy !== 1'b0)      begin errors++; $display("FAIL busy_fall: got %b want 0", dif.busy); end
                checks++; if (dif.quotient !== eq[0]) begin errors++; $display("FAIL hold_quotient: got %h want %h", dif.quotient, eq[0]); end
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] q, r;
        logic        dz, ov;
        int          lat;
        run_div(32'd50, 32'd4, 5, 32'd9, 32'd3, q, r, dz, ov, lat);
        checks++; if (q !== 32'd12) begin errors++; $display("FAIL busy_quotient: got %h want %h", q, 32'd12); end
        checks++; if (r !== 32'd2)  begin errors++; $display("FAIL busy_remainder: got %h want %h", r, 32'd2); end
        checks++; if (lat != LAT)   begin errors++; $display("FAIL busy_latency: got %0d want %0d", lat, LAT); end
        run_div(32'd9, 32'd3, 0, 32'd0, 32'd0, q, r, dz, ov, lat);
        checks++; if (q !== 32'd3)  begin errors++; $display("FAIL clean_quotient: got %h want %h", q, 32'd3); end
        checks++; if (r !== 32'd0)  begin errors++; $display("FAIL clean_remainder: got %h want %h", r, 32'd0); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] q, r;
        logic        dz, ov;
        int          lat;
        logic        saw_done;
        @(negedge clk);
        dif.start = 1'b1;
        dif.in1   = 32'd1000;
        dif.in2   = 32'd3;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (dif.busy !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %b want 0", dif.busy); end
        checks++; if (dif.quotient !== 32'd0)  begin errors++; $display("FAIL abort_quotient: got %h want 0", dif.quotient); end
        checks++; if (dif.remainder !== 32'd0) begin errors++; $display("FAIL abort_remainder: got %h want 0", dif.remainder); end
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (dif.done) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
        run_div(32'd1, 32'd1, 0, 32'd0, 32'd0, q, r, dz, ov, lat);
        checks++; if (q !== 32'd1)  begin errors++; $display("FAIL after_rst_quotient: got %h want 1", q); end
        checks++; if (r !== 32'd0)  begin errors++; $display("FAIL after_rst_remainder: got %h want 0", r); end
        checks++; if (lat != LAT)   begin errors++; $display("FAIL after_rst_latency: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q1, r1, q2, r2;
        logic        dz, ov;
        int          first, second, ndone;
        logic [31:0] gq [2];
        logic [31:0] gr [2];
        ref_div(32'd77, 32'd5, q1, r1, dz, ov);
        ref_div(32'hFFFF_FFDF, 32'd4, q2, r2, dz, ov);
        @(negedge clk);
        dif.start = 1'b1;
        dif.in1   = 32'd77;
        dif.in2   = 32'd5;
        @(posedge clk);
        #1;
        dif.in1 = 32'hFFFF_FFDF;
        dif.in2 = 32'd4;
        first  = 999;
        second = 9999;
        ndone  = 0;
        for (int c = 1; c <= 200 && ndone < 2; c++) begin
            @(negedge clk);
            if (dif.done) begin
                gq[ndone] = dif.quotient;
                gr[ndone] = dif.remainder;
                if (ndone == 0) first = c; else second = c;
                ndone++;
            end
        end
        dif.start = 1'b0;
        checks++; if (first != LAT)            begin errors++; $display("FAIL b2b_first_latency: got %0d want %0d", first, LAT); end
        checks++; if (second - first != N + 3) begin errors++; $display("FAIL b2b_interval: got %0d want %0d", second - first, N + 3); end
        checks++; if (ndone != 2)              begin errors++; $display("FAIL b2b_count: got %0d want 2", ndone); end
        else begin
            checks++; if (gq[0] !== q1) begin errors++; $display("FAIL b2b_q1: got %h want %h", gq[0], q1); end
            checks++; if (gr[0] !== r1) begin errors++; $display("FAIL b2b_r1: got %h want %h", gr[0], r1); end
            checks++; if (gq[1] !== q2) begin errors++; $display("FAIL b2b_q2: got %h want %h", gq[1], q2); end
            checks++; if (gr[1] !== r2) begin errors++; $display("FAIL b2b_r2: got %h want %h", gr[1], r2); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er;
        logic        dz, ov, edz, eov;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            a = pick_operand();
            b = pick_operand();
            ref_div(a, b, eq, er, edz, eov);
            run_div(a, b, $urandom_range(0, 33), $urandom, $urandom, q, r, dz, ov, lat);
            checks++; if (q !== eq)   begin errors++; $display("FAIL rnd_quotient %h/%h: got %h want %h", a, b, q, eq); end
            checks++; if (r !== er)   begin errors++; $display("FAIL rnd_remainder %h/%h: got %h want %h", a, b, r, er); end
            checks++; if (dz !== edz) begin errors++; $display("FAIL rnd_dzflag %h/%h: got %b want %b", a, b, dz, edz); end
            checks++; if (ov !== eov) begin errors++; $display("FAIL rnd_ovflag %h/%h: got %b want %b", a, b, ov, eov); end
            checks++; if (lat != LAT) begin errors++; $display("FAIL rnd_latency %h/%h: got %0d want %0d", a, b, lat, LAT); end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b1;
        dif.start = 1'b0;
        dif.in1   = 32'd0;
        dif.in2   = 32'd0;
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
